hamming_codec: RTL and testbench

// - Registered Hamming(12,8) SEC codec: independent encode and decode paths in one block.
// - Encoder maps 8 data bits to a 12-bit codeword.
// - Decoder corrects any single-bit error in a 12-bit codeword and flags that an error was found.
// - Sits between a byte-wide datapath and a 12-bit storage/link interface.

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_parity_gen.sv | 11 +
 rtl/hamming_codec.sv | 134 +++++++++++++
 tb/tb_hamming_codec.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(12,8) SEC codec.
// Codeword index i carries Hamming position i+1; parity lives at the
// power-of-two positions and data fills the remaining slots in order.
package hamming_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned SYN_W  = 4;

    // Codeword index of data bit d[i] (entry 0 is d0).
    localparam logic [DATA_W-1:0][3:0] DATA_IDX = {
        4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
    };

    // Codeword index of parity bit p[i] (p1, p2, p4, p8).
    localparam logic [SYN_W-1:0][3:0] PAR_IDX = {
        4'd7, 4'd3, 4'd1, 4'd0
    };

    // Even parity over the data bits each check position covers.
    function automatic logic [SYN_W-1:0] calc_parity(input logic [DATA_W-1:0] d);
        logic [SYN_W-1:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p;
    endfunction

    // Pull the eight data bits out of their codeword slots.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            d[i] = code[DATA_IDX[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational parity generator: 8 data bits -> 4 Hamming check bits.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [SYN_W-1:0]  parity_o
);

    assign parity_o = calc_parity(data_i);

endmodule

// File: rtl/hamming_codec.sv
// Registered Hamming(12,8) SEC codec with independent encode and decode paths.
// Optional build macro HAMMING_SYNDROME_OUT_EN adds dec_syndrome_o and
// dec_uncorr_o, both aligned with dec_valid_o.
module hamming_codec
    import hamming_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enc_valid_i,
    input  logic [DATA_W-1:0]   enc_data_i,
    output logic                enc_valid_o,
    output logic [CODE_W-1:0]   enc_code_o,
    input  logic                dec_valid_i,
    input  logic [CODE_W-1:0]   dec_code_i,
    output logic                dec_valid_o,
    output logic [DATA_W-1:0]   dec_data_o,
    output logic                dec_error_o
`ifdef HAMMING_SYNDROME_OUT_EN
    ,
    output logic [SYN_W-1:0]    dec_syndrome_o,
    output logic                dec_uncorr_o
`endif
);

    logic [SYN_W-1:0]  enc_par;
    logic [CODE_W-1:0] enc_code_d;
    logic              enc_valid_q;
    logic [CODE_W-1:0] enc_code_q;

    logic [DATA_W-1:0] dec_raw_data;
    logic [SYN_W-1:0]  dec_par;
    logic [SYN_W-1:0]  dec_syn;
    logic [CODE_W-1:0] dec_fixed;
    logic [DATA_W-1:0] dec_data_d;
    logic              dec_error_d;
    logic              dec_valid_q;
    logic [DATA_W-1:0] dec_data_q;
    logic              dec_error_q;

    hamming_parity_gen u_enc_par (
        .data_i   (enc_data_i),
        .parity_o (enc_par)
    );

    // Scatter data and parity bits into their codeword positions.
    always_comb begin
        enc_code_d = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            enc_code_d[DATA_IDX[i]] = enc_data_i[i];
        end
        for (int unsigned i = 0; i < SYN_W; i++) begin
            enc_code_d[PAR_IDX[i]] = enc_par[i];
        end
    end

    // Encode output registers: valid follows valid_i, code loads only on valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_valid_q <= 1'b0;
            enc_code_q  <= '0;
        end else begin
            enc_valid_q <= enc_valid_i;
            if (enc_valid_i) begin
                enc_code_q <= enc_code_d;
            end
        end
    end

    assign dec_raw_data = extract_data(dec_code_i);

    hamming_parity_gen u_dec_par (
        .data_i   (dec_raw_data),
        .parity_o (dec_par)
    );

    // Syndrome from recomputed vs received parity; flip the addressed bit
    // only when the syndrome names a real position (1..12).
    always_comb begin
        dec_syn   = '0;
        dec_fixed = dec_code_i;
        for (int unsigned i = 0; i < SYN_W; i++) begin
            dec_syn[i] = dec_par[i] ^ dec_code_i[PAR_IDX[i]];
        end
        for (int unsigned i = 0; i < CODE_W; i++) begin
            if (dec_syn == 4'(i + 1)) begin
                dec_fixed[i] = ~dec_code_i[i];
            end
        end
        dec_data_d  = extract_data(dec_fixed);
        dec_error_d = |dec_syn;
    end

`ifdef HAMMING_SYNDROME_OUT_EN
    logic [SYN_W-1:0] dec_syn_q;
    logic             dec_uncorr_d;
    logic             dec_uncorr_q;

    assign dec_uncorr_d   = (dec_syn > 4'd12);
    assign dec_syndrome_o = dec_syn_q;
    assign dec_uncorr_o   = dec_uncorr_q;
`else
    // Syndrome and uncorrectable flag are not exported in this build.
`endif

    // Decode output registers: valid follows valid_i, results load only on valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            dec_error_q <= 1'b0;
`ifdef HAMMING_SYNDROME_OUT_EN
            dec_syn_q    <= '0;
            dec_uncorr_q <= 1'b0;
`endif
        end else begin
            dec_valid_q <= dec_valid_i;
            if (dec_valid_i) begin
                dec_data_q  <= dec_data_d;
                dec_error_q <= dec_error_d;
`ifdef HAMMING_SYNDROME_OUT_EN
                dec_syn_q    <= dec_syn;
                dec_uncorr_q <= dec_uncorr_d;
`endif
            end
        end
    end

    assign enc_valid_o = enc_valid_q;
    assign enc_code_o  = enc_code_q;
    assign dec_valid_o = dec_valid_q;
    assign dec_data_o  = dec_data_q;
    assign dec_error_o = dec_error_q;

endmodule

// File: tb/tb_hamming_codec.sv
// Self-checking bench for hamming_codec: directed cases, exhaustive
// encode->decode with every single-bit flip, reset priority, and random traffic.
module tb_hamming_codec;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid_i;
    logic [7:0]  enc_data_i;
    logic        enc_valid_o;
    logic [11:0] enc_code_o;
    logic        dec_valid_i;
    logic [11:0] dec_code_i;
    logic        dec_valid_o;
    logic [7:0]  dec_data_o;
    logic        dec_error_o;
`ifdef HAMMING_SYNDROME_OUT_EN
    logic [3:0]  dec_syndrome_o;
    logic        dec_uncorr_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hamming_codec dut (
        .clk         (clk),
        .rst         (rst),
        .enc_valid_i (enc_valid_i),
        .enc_data_i  (enc_data_i),
        .enc_valid_o (enc_valid_o),
        .enc_code_o  (enc_code_o),
        .dec_valid_i (dec_valid_i),
        .dec_code_i  (dec_code_i),
        .dec_valid_o (dec_valid_o),
        .dec_data_o  (dec_data_o),
        .dec_error_o (dec_error_o)
`ifdef HAMMING_SYNDROME_OUT_EN
        ,
        .dec_syndrome_o (dec_syndrome_o),
        .dec_uncorr_o   (dec_uncorr_o)
`endif
    );

    // Reference model: classic Hamming positional view (positions 1..12).
    function automatic bit is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    function automatic logic [11:0] model_enc(input logic [7:0] d);
        logic [11:0] c;
        int k;
        int s;
        c = '0;
        k = 0;
        s = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if (!is_pow2(pos)) begin
                c[pos-1] = d[k];
                if (d[k]) s = s ^ pos;
                k++;
            end
        end
        c[0] = s[0];
        c[1] = s[1];
        c[3] = s[2];
        c[7] = s[3];
        return c;
    endfunction

    function automatic logic [3:0] model_syn(input logic [11:0] c);
        int s;
        s = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if (c[pos-1]) s = s ^ pos;
        end
        return s[3:0];
    endfunction

    function automatic logic [7:0] model_dec(input logic [11:0] c_in);
        logic [11:0] c;
        logic [7:0]  d;
        int s;
        int k;
        c = c_in;
        s = int'(model_syn(c_in));
        if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
        d = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if (!is_pow2(pos)) begin
                d[k] = c[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp_code;
        logic [7:0]  exp_data;
        logic        exp_err;
        logic [11:0] cw;
        logic [11:0] rx;
        logic        ev;
        logic        dv;
        logic [7:0]  rd;

        rst = 1'b1;
        enc_valid_i = 1'b0;
        enc_data_i  = '0;
        dec_valid_i = 1'b0;
        dec_code_i  = '0;
        step();
        step();
        chk("rst_enc_valid", 32'(enc_valid_o), 32'h0);
        chk("rst_enc_code",  32'(enc_code_o),  32'h0);
        chk("rst_dec_valid", 32'(dec_valid_o), 32'h0);
        chk("rst_dec_data",  32'(dec_data_o),  32'h0);
        chk("rst_dec_error", 32'(dec_error_o), 32'h0);
        rst = 1'b0;

        // Directed encode/decode pairs.
        enc_valid_i = 1'b1; enc_data_i = 8'h00;
        dec_valid_i = 1'b1; dec_code_i = 12'hF77;
        step();
        chk("enc_00_valid", 32'(enc_valid_o), 32'h1);
        chk("enc_00",       32'(enc_code_o),  32'h000);
        chk("dec_F77_valid", 32'(dec_valid_o), 32'h1);
        chk("dec_F77_data", 32'(dec_data_o),  32'hFF);
        chk("dec_F77_err",  32'(dec_error_o), 32'h0);

        enc_data_i = 8'h01; dec_code_i = 12'h000;
        step();
        chk("enc_01",       32'(enc_code_o),  32'h007);
        chk("dec_000_data", 32'(dec_data_o),  32'h00);
        chk("dec_000_err",  32'(dec_error_o), 32'h0);

        enc_data_i = 8'hFF; dec_code_i = 12'hF57;
        step();
        chk("enc_FF",       32'(enc_code_o),  32'hF77);
        chk("dec_F57_data", 32'(dec_data_o),  32'hFF);
        chk("dec_F57_err",  32'(dec_error_o), 32'h1);
`ifdef HAMMING_SYNDROME_OUT_EN
        chk("dec_F57_syn",    32'(dec_syndrome_o), 32'h6);
        chk("dec_F57_uncorr", 32'(dec_uncorr_o),   32'h0);
`endif

        dec_code_i = 12'h006; enc_valid_i = 1'b0; enc_data_i = 8'h5A;
        step();
        chk("enc_idle_valid", 32'(enc_valid_o), 32'h0);
        chk("enc_hold",       32'(enc_code_o),  32'hF77);
        chk("dec_006_data",   32'(dec_data_o),  32'h01);
        chk("dec_006_err",    32'(dec_error_o), 32'h1);

        dec_valid_i = 1'b0; dec_code_i = 12'hABC;
        step();
        chk("dec_idle_valid", 32'(dec_valid_o), 32'h0);
        chk("dec_hold_data",  32'(dec_data_o),  32'h01);
        chk("dec_hold_err",   32'(dec_error_o), 32'h1);

        // Exhaustive: encode each byte, then decode it clean and with each single flip.
        for (int d = 0; d < 256; d++) begin
            enc_valid_i = 1'b1; enc_data_i = 8'(d); dec_valid_i = 1'b0;
            step();
            exp_code = model_enc(8'(d));
            chk("exh_enc", 32'(enc_code_o), 32'(exp_code));
            cw = enc_code_o;
            enc_valid_i = 1'b0;
            for (int f = -1; f < 12; f++) begin
                rx = cw;
                if (f >= 0) rx[f] = ~rx[f];
                dec_valid_i = 1'b1; dec_code_i = rx;
                step();
                chk("exh_dec_data", 32'(dec_data_o),  32'(d));
                chk("exh_dec_err",  32'(dec_error_o), (f >= 0) ? 32'h1 : 32'h0);
`ifdef HAMMING_SYNDROME_OUT_EN
                chk("exh_dec_syn", 32'(dec_syndrome_o), 32'(f + 1));
`endif
            end
        end

        // Reset dominates simultaneous valid on both paths.
        rst = 1'b1;
        enc_valid_i = 1'b1; enc_data_i = 8'hFF;
        dec_valid_i = 1'b1; dec_code_i = 12'hF57;
        step();
        chk("rstv_enc_valid", 32'(enc_valid_o), 32'h0);
        chk("rstv_enc_code",  32'(enc_code_o),  32'h0);
        chk("rstv_dec_valid", 32'(dec_valid_o), 32'h0);
        chk("rstv_dec_data",  32'(dec_data_o),  32'h0);
        chk("rstv_dec_err",   32'(dec_error_o), 32'h0);
`ifdef HAMMING_SYNDROME_OUT_EN
        chk("rstv_syn",    32'(dec_syndrome_o), 32'h0);
        chk("rstv_uncorr", 32'(dec_uncorr_o),   32'h0);
`endif
        rst = 1'b0;
        step();
        chk("post_rst_enc_valid", 32'(enc_valid_o), 32'h1);
        chk("post_rst_enc_code",  32'(enc_code_o),  32'hF77);
        chk("post_rst_dec_valid", 32'(dec_valid_o), 32'h1);
        chk("post_rst_dec_data",  32'(dec_data_o),  32'hFF);
        chk("post_rst_dec_err",   32'(dec_error_o), 32'h1);

        // Random traffic on both paths, arbitrary received words (multi-bit
        // errors and invalid syndromes included), with hold on idle cycles.
        exp_code = enc_code_o;
        exp_data = dec_data_o;
        exp_err  = dec_error_o;
        for (int n = 0; n < 400; n++) begin
            ev = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rx = 12'($urandom);
            enc_valid_i = ev; enc_data_i = rd;
            dec_valid_i = dv; dec_code_i = rx;
            step();
            if (ev) exp_code = model_enc(rd);
            if (dv) begin
                exp_data = model_dec(rx);
                exp_err  = (model_syn(rx) != 4'd0);
            end
            chk("rnd_enc_valid", 32'(enc_valid_o), 32'(ev));
            chk("rnd_enc_code",  32'(enc_code_o),  32'(exp_code));
            chk("rnd_dec_valid", 32'(dec_valid_o), 32'(dv));
            chk("rnd_dec_data",  32'(dec_data_o),  32'(exp_data));
            chk("rnd_dec_err",   32'(dec_error_o), 32'(exp_err));
`ifdef HAMMING_SYNDROME_OUT_EN
            if (dv) begin
                chk("rnd_syn",    32'(dec_syndrome_o), 32'(model_syn(rx)));
                chk("rnd_uncorr", 32'(dec_uncorr_o),   32'(model_syn(rx) > 4'd12));
            end
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
